// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD scheduler slice.
//   state_e  : scheduler FSM states (IDLE / RUN / DONE)
//   rr_pick  : round-robin priority search over up to MAX_REQ requesters
package gcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int MAX_REQ = 16;
    localparam int MAX_IDW = 4;

    // Returns the index of the first set bit of req, searching upward from
    // ptr and wrapping at nreq. Returns 0 when req is empty; callers qualify
    // the result with |req.
    function automatic logic [MAX_IDW-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [MAX_IDW-1:0] ptr,
        input int                 nreq
    );
        logic [MAX_IDW-1:0] pick;
        logic               found;
        int                 idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = (int'(ptr) + i) % nreq;
            if (i < nreq && !found && req[idx[MAX_IDW-1:0]]) begin
                pick  = idx[MAX_IDW-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/gcd_core.sv
// Subtract-based GCD engine datapath.
//   load        : capture a_ld/b_ld into the A/B registers
//   step        : perform one subtraction (ignored when load is high)
//   sub_b       : 1 -> B <= B - A, 0 -> A <= A - B
//   a, b        : current register contents
//   lt/gt/eq    : A<B, A>B, A==B
//   a_z/b_z     : A==0, B==0
module gcd_core
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             sub_b,
    input  logic [WIDTH-1:0] a_ld,
    input  logic [WIDTH-1:0] b_ld,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             lt,
    output logic             gt,
    output logic             eq,
    output logic             a_z,
    output logic             b_z
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff;

    // One shared subtractor; operand order follows the register being updated,
    // so the smaller value is always the subtrahend and no underflow occurs.
    always_comb begin
        diff = sub_b ? (b_q - a_q) : (a_q - b_q);
        a_d  = a_q;
        b_d  = b_q;
        if (load) begin
            a_d = a_ld;
            b_d = b_ld;
        end else if (step) begin
            if (sub_b) b_d = diff;
            else       a_d = diff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign a   = a_q;
    assign b   = b_q;
    assign lt  = (a_q < b_q);
    assign gt  = (a_q > b_q);
    assign eq  = (a_q == b_q);
    assign a_z = (a_q == '0);
    assign b_z = (b_q == '0);

endmodule

// File: rtl/gcd_scheduler.sv
// Round-robin scheduler sharing one gcd_core among NREQ requesters.
//   req/a_in/b_in : per-requester job request (level) and packed operands
//   grant         : one-hot pulse in IDLE; operands captured on that edge
//   busy          : state is not IDLE
//   res_*         : result port (valid/ready), tagged with requester index
//
// Result handshake: res_valid is high exactly while in DONE. res_data, res_id
// and res_zero are stable while res_valid is high; the result is consumed on
// the rising edge where res_valid and res_ready are both high. res_ready is
// ignored at all other times.
module gcd_scheduler
    import gcd_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_data,
    output logic [IDW-1:0]        res_id,
    output logic                  res_zero
);

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [IDW-1:0]   res_id_q, res_id_d;
    logic             res_zero_q, res_zero_d;

    logic [IDW-1:0]   pick;
    logic             load, step;
    logic [WIDTH-1:0] eng_a, eng_b;
    logic             eng_lt, eng_gt, eng_eq, eng_az, eng_bz;

    assign pick = IDW'(rr_pick(MAX_REQ'(req), MAX_IDW'(rr_ptr_q), NREQ));

    gcd_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .sub_b (eng_lt),
        .a_ld  (a_in[pick*WIDTH +: WIDTH]),
        .b_ld  (b_in[pick*WIDTH +: WIDTH]),
        .a     (eng_a),
        .b     (eng_b),
        .lt    (eng_lt),
        .gt    (eng_gt),
        .eq    (eng_eq),
        .a_z   (eng_az),
        .b_z   (eng_bz)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        id_d       = id_q;
        res_data_d = res_data_q;
        res_id_d   = res_id_q;
        res_zero_d = res_zero_q;
        grant      = '0;
        load       = 1'b0;
        step       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant    = NREQ'(1) << pick;
                    load     = 1'b1;
                    id_d     = pick;
                    rr_ptr_d = (pick == IDW'(NREQ - 1)) ? '0 : pick + IDW'(1);
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                // Zero check comes first: gcd(0,x) = x, and both-zero is flagged.
                if (eng_az || eng_bz) begin
                    res_data_d = eng_a | eng_b;
                    res_zero_d = eng_az && eng_bz;
                    res_id_d   = id_q;
                    state_d    = ST_DONE;
                end else if (eng_eq) begin
                    res_data_d = eng_a;
                    res_zero_d = 1'b0;
                    res_id_d   = id_q;
                    state_d    = ST_DONE;
                end else if (eng_lt || eng_gt) begin
                    step = 1'b1;
                end
            end
            ST_DONE: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            id_q       <= '0;
            res_data_q <= '0;
            res_id_q   <= '0;
            res_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            id_q       <= id_d;
            res_data_q <= res_data_d;
            res_id_q   <= res_id_d;
            res_zero_q <= res_zero_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign res_valid = (state_q == ST_DONE);
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign res_zero  = res_zero_q;

endmodule

// File: doc/gcd_scheduler.md
# gcd_scheduler

Round-robin scheduler that shares one iterative subtract-based GCD engine among `NREQ` requesters. It accepts one operand pair at a time and sequences the engine until its operands are equal. It then returns the result tagged with the requester index on a valid/ready output port. It sits between the client blocks and the shared GCD datapath and owns all load and select sequencing for that datapath.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `WIDTH`, 16: operand and result width in bits.
- `IDW`, `$clog2(NREQ)`: width of the requester index.

- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `req`: input, `NREQ` bits. Per-requester job request, level.
- `a_in`: input, `NREQ*WIDTH` bits. Operand A per requester; requester i uses slice `[i*WIDTH +: WIDTH]`.
- `b_in`: input, `NREQ*WIDTH` bits. Operand B per requester, packed the same way.
- `grant`: output, `NREQ` bits. One-hot, one-cycle pulse; operands of the granted requester are captured on this edge.
- `busy`: output, 1 bit. High whenever the state is not IDLE.
- `res_valid`: output, 1 bit. Result available.
- `res_ready`: input, 1 bit. Consumer accepts the result.
- `res_data`: output, `WIDTH` bits. GCD result.
- `res_id`: output, `IDW` bits. Index of the requester that owns the result.
- `res_zero`: output, 1 bit. Both operands were 0; `res_data` = 0.

## Operation
- States are IDLE, RUN and DONE.
- **IDLE**
  - If `req` ≠ 0, select the first set bit searching upward from `rr_ptr`, with wrap-around.
  - Assert `grant` for that bit combinationally in this cycle.
  - On the clock edge: capture A and B into the engine, latch the index, set `rr_ptr` = (index+1) mod `NREQ`, and go to RUN.
  - If `req` = 0: `grant` = 0 and the state stays IDLE.
- **RUN**, evaluated each cycle on the engine flags:
  - A=0 or B=0: result = A|B, `res_zero` = (A==0 && B==0), go to DONE.
  - A==B: result = A, go to DONE.
  - A<B: B ← B−A, stay in RUN.
  - A>B: A ← A−B, stay in RUN.
  - Subtractions are unsigned `WIDTH`-bit. By construction they never underflow.
- **DONE**
  - `res_valid` = 1.
  - `res_data`, `res_id` and `res_zero` are held stable until `res_ready` is sampled high.
  - On that edge go to IDLE.
  - No grant is issued while in RUN or DONE.
- **Requester rules**
  - A requester holds `req` and its operands stable until it sees `grant`.
  - A requester that keeps `req` high after its grant is treated as submitting a new job.
  - `req` may drop without a grant; nothing is recorded.
- **Reset values**
  - `grant` = 0, `busy` = 0, `res_valid` = 0, `res_data` = 0, `res_id` = 0, `res_zero` = 0.
  - `rr_ptr` = 0, state = IDLE, engine registers = 0.
- **Reset asserted mid-job:** outputs return to reset values immediately, without waiting for a clock edge. The job is discarded and no result is produced.

## Timing
- Grant is in cycle 0, combinational from `req` in IDLE. The first RUN cycle is cycle 1.
- Latency from grant to the first cycle with `res_valid` = 1 is 2 + S cycles, where S is the number of subtractions.
  - Examples: (7,7) → cycle 2; (0,5) → cycle 2; (12,18) → cycle 4.
- The worst-case S is 2^WIDTH − 2, for example (1, 2^WIDTH−1). There is no timeout.
- A result is consumed on the edge where `res_ready` is high. The earliest next grant is the following cycle, in IDLE, so throughput is at most one job per 3 + S cycles.
- `res_ready` high while in IDLE or RUN is ignored.
- When `req` and `res_ready` are both high during DONE, the result is consumed first. The new arbitration happens in the next cycle and uses the already-advanced `rr_ptr`.

## Structure
- **Package `gcd_pkg`:** holds the state enum (IDLE/RUN/DONE) and a helper function for the round-robin priority search.
- **Sub-module `gcd_core`** (engine datapath):
  - A and B registers with a `load` input and a `step` input.
  - Comparator outputs `lt`, `gt`, `eq`, and zero flags `a_z`, `b_z`.
  - Subtractor, with muxes steered by the scheduler.
- The FSM, arbiter, pointer and result registers live in `gcd_scheduler`.

## Test plan
- **Reset mid-job:** `rst_n` low, then high; single `req[0]` with (12,18).
  - `grant` = 0001 in cycle 0.
  - `res_valid` in cycle 4 with `res_data` = 6, `res_id` = 0, `res_zero` = 0.
  - Pulling `rst_n` low during RUN of a rerun clears `busy` and `res_valid` immediately.
- **Round robin:** `req` = 1111 held, with `res_ready` = 1.
  - Grants go 0001, 0010, 0100, 1000, 0001.
  - `res_id` follows the sequence 0, 1, 2, 3, 0.
- **Zero operands:**
  - (0,9) → 9 with `res_zero` = 0.
  - (0,0) → 0 with `res_zero` = 1.
  - Both have `res_valid` in cycle 2.
- **Backpressure:** (35,21) with `res_ready` = 0 for 5 cycles.
  - `res_valid` stays high with `res_data` = 7.
  - `req[1]` is pending but gets no grant.
  - The grant to requester 1 comes one cycle after `res_ready` goes high.
- **Worst case at `WIDTH` = 8:** (1,255) → `res_data` = 1, `res_valid` in cycle 2+254.
- **Exhaustive sweep at `WIDTH` = 6:** every operand pair versus a reference model; check the result and that latency equals 2 + S.
